// File: rtl/affine_stencil_ub_if.sv
// -----------------------------------------------------------------------------
// affine_stencil_ub_if
// Bundle of the data/handshake signals of the affine stencil unified buffer.
//   flush        : synchronous restart of both iteration counters
//   wen / wdata  : write strobe and write data
//   ren          : read strobe
//   rdata        : NUM_RD packed taps, tap k at [k*DATA_W +: DATA_W]
//   rvalid       : rdata valid (one cycle after ren)
//   wr_done      : pulse after the last write of the write domain
//   rd_done      : pulse after the last read of the read domain
//   wr_ctrl_vars : write loop indices, dim d at [d*16 +: 16]
//   rd_ctrl_vars : read loop indices, same packing
// master drives the strobes (producer/consumer side), slave is the buffer.
// -----------------------------------------------------------------------------
interface affine_stencil_ub_if #(
  parameter int DATA_W = 16,
  parameter int NUM_RD = 4,
  parameter int DIMS   = 2
);
  logic                     flush;
  logic                     wen;
  logic [DATA_W-1:0]        wdata;
  logic                     ren;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     rvalid;
  logic                     wr_done;
  logic                     rd_done;
  logic [DIMS*16-1:0]       wr_ctrl_vars;
  logic [DIMS*16-1:0]       rd_ctrl_vars;

  modport master (
    output flush, wen, wdata, ren,
    input  rdata, rvalid, wr_done, rd_done, wr_ctrl_vars, rd_ctrl_vars
  );

  modport slave (
    input  flush, wen, wdata, ren,
    output rdata, rvalid, wr_done, rd_done, wr_ctrl_vars, rd_ctrl_vars
  );
endinterface

// File: rtl/affine_stencil_ub.sv
// -----------------------------------------------------------------------------
// affine_stencil_ub
// Unified buffer with affine write/read address generators. A write loop nest
// (WR_EXTENT/WR_STRIDE/WR_OFFSET) places incoming words in a DEPTH-word RAM;
// a read loop nest (RD_EXTENT/RD_STRIDE) fetches NUM_RD taps per read, each
// tap displaced by its own RD_OFFSET. Defaults implement a 2x2 down-sample
// window over a 64x64 image.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset (priority over flush)
//   bus   : affine_stencil_ub_if.slave (flush, wen, wdata, ren, rdata,
//           rvalid, wr_done, rd_done, wr_ctrl_vars, rd_ctrl_vars)
// DEPTH must be a power of two; addresses wrap modulo DEPTH.
// -----------------------------------------------------------------------------
module affine_stencil_ub #(
  parameter int DATA_W            = 16,
  parameter int DEPTH             = 4096,
  parameter int DIMS              = 2,
  parameter int NUM_RD            = 4,
  parameter int WR_EXTENT [DIMS]  = '{64, 64},
  parameter int WR_STRIDE [DIMS]  = '{64, 1},
  parameter int WR_OFFSET         = 0,
  parameter int RD_EXTENT [DIMS]  = '{32, 32},
  parameter int RD_STRIDE [DIMS]  = '{128, 2},
  parameter int RD_OFFSET [NUM_RD] = '{0, 1, 64, 65}
) (
  input  logic                clk,
  input  logic                rst_n,
  affine_stencil_ub_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  // Storage: no reset, contents survive flush and reset.
  logic [DATA_W-1:0] mem [DEPTH];

  // Loop indices, dim 0 outermost, dim DIMS-1 innermost.
  logic [DIMS-1:0][15:0]       wcnt_q, wcnt_d;
  logic [DIMS-1:0][15:0]       rcnt_q, rcnt_d;
  logic                        wr_last, rd_last;
  logic [31:0]                 wsum, rsum;
  logic [AW-1:0]               waddr;
  logic [AW-1:0]               raddr [NUM_RD];
  logic [NUM_RD-1:0][DATA_W-1:0] rdata_q;
  logic                        rvalid_q, wr_done_q, rd_done_q;
  logic                        wr_fire, rd_fire;

  // Strobes are only honoured outside reset and flush.
  assign wr_fire = rst_n && !bus.flush && bus.wen;
  assign rd_fire = rst_n && !bus.flush && bus.ren;

  // Odometer advance of the write nest; wr_last stays 1 only if every dim
  // wrapped, i.e. this advance leaves the final point of the domain.
  always_comb begin
    wcnt_d  = wcnt_q;
    wr_last = 1'b1;
    for (int d = DIMS - 1; d >= 0; d--) begin
      if (wr_last) begin
        if (wcnt_q[d] == 16'(WR_EXTENT[d] - 1)) begin
          wcnt_d[d] = '0;
        end else begin
          wcnt_d[d] = wcnt_q[d] + 16'd1;
          wr_last   = 1'b0;
        end
      end
    end
  end

  always_comb begin
    rcnt_d  = rcnt_q;
    rd_last = 1'b1;
    for (int d = DIMS - 1; d >= 0; d--) begin
      if (rd_last) begin
        if (rcnt_q[d] == 16'(RD_EXTENT[d] - 1)) begin
          rcnt_d[d] = '0;
        end else begin
          rcnt_d[d] = rcnt_q[d] + 16'd1;
          rd_last   = 1'b0;
        end
      end
    end
  end

  // Affine addresses evaluated at 32 bits, then truncated (mod DEPTH).
  always_comb begin
    wsum = 32'(WR_OFFSET);
    rsum = 32'd0;
    for (int d = 0; d < DIMS; d++) begin
      wsum = wsum + 32'(WR_STRIDE[d]) * {16'd0, wcnt_q[d]};
      rsum = rsum + 32'(RD_STRIDE[d]) * {16'd0, rcnt_q[d]};
    end
  end

  assign waddr = wsum[AW-1:0];

  // Taps share the base sum and differ only in their constant offset.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_tap_addr
    logic [31:0] tap_sum;
    assign tap_sum    = rsum + 32'(RD_OFFSET[gi]);
    assign raddr[gi]  = tap_sum[AW-1:0];
  end

  // Write port. Reads below sample the old word on a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
    end else if (bus.flush) begin
      // rdata deliberately holds its value across a flush.
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      rvalid_q  <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      wr_done_q <= bus.wen && wr_last;
      rd_done_q <= bus.ren && rd_last;
      rvalid_q  <= bus.ren;
      if (bus.wen) begin
        wcnt_q <= wcnt_d;
      end
      if (rd_fire) begin
        rcnt_q <= rcnt_d;
        for (int k = 0; k < NUM_RD; k++) begin
          rdata_q[k] <= mem[raddr[k]];
        end
      end
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.rvalid       = rvalid_q;
  assign bus.wr_done      = wr_done_q;
  assign bus.rd_done      = rd_done_q;
  assign bus.wr_ctrl_vars = wcnt_q;
  assign bus.rd_ctrl_vars = rcnt_q;

endmodule
